csr_regfile_slave: RTL and testbench
====================================

Name: csr_regfile_slave

Overview:
- Register-bank slave that sits directly downstream of the JTAG-to-AVMM address decoder.
- Consumes the decoded 16-bit offset, write/read strobes and write data for base 0x5000_xxxx.
- Returns read data with a fixed-latency rd_dvalid pulse.
- Holds design control/mode registers, a read-only status mirror, W1C sticky error flags and two saturating traffic counters.

Parameters:
- READ_LATENCY, 2, cycles from rd_en to rd_dvalid; legal range 1..4.
- CNT_WIDTH, 32, traffic counter width; legal range 8..32; counters are zero-extended on read.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_rd_addr  in  16  byte offset within the CSR window.
- wr_en  in  1  single-cycle write strobe.
- rd_en  in  1  single-cycle read strobe.
- wr_data  in  32  write data.
- rd_data  out  32  read data; drives the decoder's rd_datain.
- rd_dvalid  out  1  read data valid; drives the decoder's rd_dvalid.
- ctrl_out  out  32  CTRL register 0x0000, bits 30:0.
- mode_out  out  32  MODE register 0x0004.
- status_in  in  32  live status, readable at 0x0008.
- err_pulse_in  in  8  error event pulses, sticky at 0x000C.
- wr_beat_inc  in  1  increments WR_CNT at 0x0010.
- rd_beat_inc  in  1  increments RD_CNT at 0x0014.

Behaviour:
- Reset values: ctrl_out=0; mode_out=0x0000_0001; sticky=0; WR_CNT=RD_CNT=0; rd_data=0; rd_dvalid=0; read pipeline emptied.
- Address decode:
  - Only word-aligned offsets are decoded (addr[1:0]==0).
  - Misaligned or unmapped write: ignored, no side effects.
  - Misaligned or unmapped read: returns 0xDEAD_ADD0 with normal latency.
- Register map:
  - 0x0000 CTRL, RW.
    - Bit 31 is write-only, self-clearing COUNTER_CLEAR; it always reads 0.
  - 0x0004 MODE, RW.
  - 0x0008 STATUS, RO; writes ignored.
  - 0x000C ERR, bits 7:0 W1C sticky; bits 31:8 read 0.
  - 0x0010 WR_CNT, RO.
  - 0x0014 RD_CNT, RO.
- Writes:
  - Take effect at the clock edge where wr_en=1.
  - New value is visible on ctrl_out/mode_out the next cycle.
- Reads:
  - Read data is sampled in the rd_en cycle T; rd_dvalid=1 for exactly one cycle at T+READ_LATENCY with that data.
  - Pipeline is READ_LATENCY deep, so one read per cycle is sustained back-to-back with no bubbles and responses in order.
  - rd_data holds its last value when rd_dvalid=0.
- Simultaneous wr_en and rd_en to the same offset: the read returns the pre-write value.
- ERR sticky: bit i sets on err_pulse_in[i]=1. Set and W1C clear in the same cycle: set wins, bit stays 1.
- Counters:
  - +1 per cycle the inc input is high; saturate at all-ones and never wrap.
  - COUNTER_CLEAR write zeroes both counters the following edge.
  - Clear and increment in the same cycle: clear wins, result 0.
- Reset mid-read: in-flight reads are discarded and no rd_dvalid is issued after reset asserts.

Optional Feature:
- Macro: CSR_WR_CNT_EN.
- Defined:
  - Adds register 0x0018 CSR_WR_CNT, RO, 16 bits, zero-extended.
  - Counts every accepted wr_en whether mapped or not; wraps 0xFFFF->0x0000.
  - Reset value 0; also cleared by COUNTER_CLEAR.
- Undefined: 0x0018 is unmapped and reads 0xDEAD_ADD0.

Test Plan:
- Reset, then read 0x0004 at T -> rd_dvalid only at T+2, rd_data=0x0000_0001; all other outputs 0.
- Write CTRL=0x8000_00A5, then read 0x0000 -> ctrl_out=0x0000_00A5, read returns 0x0000_00A5, WR_CNT=RD_CNT=0.
- Pulse err_pulse_in=0x81; write ERR=0x01 in the same cycle as err_pulse_in=0x01 -> ERR reads 0x81; write 0x80 -> ERR reads 0x01.
- Hold wr_beat_inc for 300 cycles with CNT_WIDTH=8 -> WR_CNT reads 0x0000_00FF; clear during inc -> 0.
- Issue reads on 4 consecutive cycles to 0x0000, 0x0004, 0x0002, 0x0040 -> 4 consecutive rd_dvalid with 0x0, 0x1, 0xDEAD_ADD0, 0xDEAD_ADD0; reset the cycle after the last read -> no further rd_dvalid.
- With CSR_WR_CNT_EN defined: 3 writes -> 0x0018 reads 0x0000_0003. Without it: 0x0018 reads 0xDEAD_ADD0.

Source files
------------

// File: rtl/csr_regfile_slave.sv
// CSR bank behind the JTAG-to-AVMM decoder: CTRL/MODE, status mirror, W1C errors, traffic counters.
// Latency: rd_dvalid exactly READ_LATENCY cycles after rd_en; writes land at the strobe edge.
// Backpressure: none; one read and/or one write accepted every cycle. Option macro: CSR_WR_CNT_EN.
module csr_regfile_slave #(
    parameter int READ_LATENCY = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] wr_rd_addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_dvalid,
    output logic [31:0] ctrl_out,
    output logic [31:0] mode_out,
    input  logic [31:0] status_in,
    input  logic [7:0]  err_pulse_in,
    input  logic        wr_beat_inc,
    input  logic        rd_beat_inc
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("csr_regfile_slave: READ_LATENCY must be 1..4");
    end
    if (CNT_WIDTH < 8 || CNT_WIDTH > 32) begin : g_bad_cnt_width
        $error("csr_regfile_slave: CNT_WIDTH must be 8..32");
    end

    localparam logic [13:0] W_CTRL    = 14'h0000;
    localparam logic [13:0] W_MODE    = 14'h0001;
    localparam logic [13:0] W_STATUS  = 14'h0002;
    localparam logic [13:0] W_ERR     = 14'h0003;
    localparam logic [13:0] W_WR_CNT  = 14'h0004;
    localparam logic [13:0] W_RD_CNT  = 14'h0005;
`ifdef CSR_WR_CNT_EN
    localparam logic [13:0] W_CSR_CNT = 14'h0006;
`endif
    localparam logic [31:0]          UNMAPPED = 32'hDEAD_ADD0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic                 aligned;
    logic [13:0]          word;
    logic                 wr_ctrl;
    logic                 wr_mode;
    logic                 wr_err;
    logic                 cnt_clr;
    logic [30:0]          ctrl_q;
    logic [31:0]          mode_q;
    logic [7:0]           err_q;
    logic [CNT_WIDTH-1:0] wr_cnt_q;
    logic [CNT_WIDTH-1:0] rd_cnt_q;
    logic [31:0]          rd_mux;
`ifdef CSR_WR_CNT_EN
    logic [15:0]          csr_wr_cnt_q;
`endif

    assign aligned = (wr_rd_addr[1:0] == 2'b00);
    assign word    = wr_rd_addr[15:2];
    assign wr_ctrl = wr_en && aligned && (word == W_CTRL);
    assign wr_mode = wr_en && aligned && (word == W_MODE);
    assign wr_err  = wr_en && aligned && (word == W_ERR);
    // COUNTER_CLEAR is a pulse carried by the CTRL write itself; it is never stored.
    assign cnt_clr = wr_ctrl && wr_data[31];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            mode_q <= 32'h0000_0001;
        end else begin
            if (wr_ctrl) ctrl_q <= wr_data[30:0];
            if (wr_mode) mode_q <= wr_data;
        end
    end

    assign ctrl_out = {1'b0, ctrl_q};
    assign mode_out = mode_q;

    // A new error event in the same cycle as its W1C survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= (err_q & ~(wr_err ? wr_data[7:0] : 8'h00)) | err_pulse_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            wr_cnt_q <= '0;
        end else if (wr_beat_inc && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            rd_cnt_q <= '0;
        end else if (rd_beat_inc && (rd_cnt_q != CNT_MAX)) begin
            rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
        end
    end

`ifdef CSR_WR_CNT_EN
    // Counts every write strobe, mapped or not, and wraps.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            csr_wr_cnt_q <= '0;
        end else if (wr_en) begin
            csr_wr_cnt_q <= csr_wr_cnt_q + 16'd1;
        end
    end
`endif

    // Sampled before this edge's writes land, so a same-offset read sees the old value.
    always_comb begin
        rd_mux = UNMAPPED;
        if (aligned) begin
            case (word)
                W_CTRL:    rd_mux = {1'b0, ctrl_q};
                W_MODE:    rd_mux = mode_q;
                W_STATUS:  rd_mux = status_in;
                W_ERR:     rd_mux = {24'h0, err_q};
                W_WR_CNT:  rd_mux = 32'(wr_cnt_q);
                W_RD_CNT:  rd_mux = 32'(rd_cnt_q);
`ifdef CSR_WR_CNT_EN
                W_CSR_CNT: rd_mux = {16'h0, csr_wr_cnt_q};
`endif
                default:   rd_mux = UNMAPPED;
            endcase
        end
    end

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [31:0]             dat_pipe [READ_LATENCY];

    // Data stages only load behind a valid, so the last stage holds the previous response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            if (rd_en) dat_pipe[0] <= rd_mux;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    // Masking with rst_n keeps a stale response from escaping in the cycle reset is asserted.
    assign rd_dvalid = vld_pipe[READ_LATENCY-1] && rst_n;
    assign rd_data   = dat_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_csr_regfile_slave.sv
// Directed bench for csr_regfile_slave (READ_LATENCY=2, CNT_WIDTH=8); honours CSR_WR_CNT_EN.
module tb_csr_regfile_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wr_rd_addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_dvalid;
    logic [31:0] ctrl_out;
    logic [31:0] mode_out;
    logic [31:0] status_in;
    logic [7:0]  err_pulse_in;
    logic        wr_beat_inc;
    logic        rd_beat_inc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    csr_regfile_slave #(.READ_LATENCY(2), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_rd_addr(wr_rd_addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data), .rd_dvalid(rd_dvalid), .ctrl_out(ctrl_out),
        .mode_out(mode_out), .status_in(status_in), .err_pulse_in(err_pulse_in),
        .wr_beat_inc(wr_beat_inc), .rd_beat_inc(rd_beat_inc)
    );

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_rd_addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns the response and the cycle count from rd_en to rd_dvalid (99 on timeout).
    task automatic rd(input logic [15:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        wr_rd_addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        lat = 1;
        d = 'x;
        while (lat < 8 && !rd_dvalid) begin
            @(negedge clk);
            lat++;
        end
        if (rd_dvalid) d = rd_data;
        else lat = 99;
    endtask

    task automatic test_reset();
        logic [31:0] d; int lat;
        rst_n = 1'b0; wr_rd_addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        status_in = '0; err_pulse_in = '0; wr_beat_inc = 1'b0; rd_beat_inc = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tests++; if (ctrl_out !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h want 0", ctrl_out); end
        tests++; if (mode_out !== 32'h1) begin fails++; $display("FAIL reset_mode: got %h want 1", mode_out); end
        tests++; if (rd_dvalid !== 1'b0) begin fails++; $display("FAIL reset_dvalid: got %b want 0", rd_dvalid); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        rd(16'h0004, d, lat);
        tests++; if (lat !== 2) begin fails++; $display("FAIL reset_rd_latency: got %0d want 2", lat); end
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL reset_rd_mode: got %h want 1", d); end
    endtask

    task automatic test_ctrl_mode();
        logic [31:0] d; int lat;
        wr(16'h0000, 32'h8000_00A5);
        tests++; if (ctrl_out !== 32'h0000_00A5) begin fails++; $display("FAIL ctrl_out: got %h want 000000a5", ctrl_out); end
        rd(16'h0000, d, lat);
        tests++; if (d !== 32'h0000_00A5) begin fails++; $display("FAIL ctrl_read: got %h want 000000a5", d); end
        rd(16'h0010, d, lat);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL wr_cnt_zero: got %h want 0", d); end
        rd(16'h0014, d, lat);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rd_cnt_zero: got %h want 0", d); end
        wr(16'h0004, 32'h1234_5678);
        tests++; if (mode_out !== 32'h1234_5678) begin fails++; $display("FAIL mode_out: got %h want 12345678", mode_out); end
        wr(16'h0001, 32'hFFFF_FFFF);
        tests++; if (ctrl_out !== 32'h0000_00A5) begin fails++; $display("FAIL misaligned_wr_ctrl: got %h want 000000a5", ctrl_out); end
        tests++; if (mode_out !== 32'h1234_5678) begin fails++; $display("FAIL misaligned_wr_mode: got %h want 12345678", mode_out); end
        status_in = 32'hCAFE_F00D;
        wr(16'h0008, 32'h0);
        rd(16'h0008, d, lat);
        tests++; if (d !== 32'hCAFE_F00D) begin fails++; $display("FAIL status_read: got %h want cafef00d", d); end
        rd(16'h0006, d, lat);
        tests++; if (d !== 32'hDEAD_ADD0) begin fails++; $display("FAIL misaligned_rd: got %h want deadadd0", d); end
    endtask

    task automatic test_err();
        logic [31:0] d; int lat;
        @(negedge clk); err_pulse_in = 8'h81;
        @(negedge clk); err_pulse_in = 8'h00;
        rd(16'h000C, d, lat);
        tests++; if (d !== 32'h81) begin fails++; $display("FAIL err_sticky: got %h want 81", d); end
        @(negedge clk);
        wr_rd_addr = 16'h000C; wr_data = 32'h1; wr_en = 1'b1; err_pulse_in = 8'h01;
        @(negedge clk);
        wr_en = 1'b0; err_pulse_in = 8'h00;
        rd(16'h000C, d, lat);
        tests++; if (d !== 32'h81) begin fails++; $display("FAIL err_set_wins: got %h want 81", d); end
        wr(16'h000C, 32'hFFFF_FF80);
        rd(16'h000C, d, lat);
        tests++; if (d !== 32'h01) begin fails++; $display("FAIL err_w1c: got %h want 01", d); end
    endtask

    task automatic test_counters();
        logic [31:0] d; int lat;
        @(negedge clk); wr_beat_inc = 1'b1;
        repeat (300) @(negedge clk);
        wr_beat_inc = 1'b0;
        rd(16'h0010, d, lat);
        tests++; if (d !== 32'h0000_00FF) begin fails++; $display("FAIL wr_cnt_saturate: got %h want 000000ff", d); end
        @(negedge clk); rd_beat_inc = 1'b1;
        repeat (5) @(negedge clk);
        rd_beat_inc = 1'b0;
        rd(16'h0014, d, lat);
        tests++; if (d !== 32'h5) begin fails++; $display("FAIL rd_cnt_count: got %h want 5", d); end
        @(negedge clk);
        wr_beat_inc = 1'b1; rd_beat_inc = 1'b1;
        wr_rd_addr = 16'h0000; wr_data = 32'h8000_00A5; wr_en = 1'b1;
        @(negedge clk);
        wr_beat_inc = 1'b0; rd_beat_inc = 1'b0; wr_en = 1'b0;
        rd(16'h0010, d, lat);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL wr_cnt_clear: got %h want 0", d); end
        rd(16'h0014, d, lat);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rd_cnt_clear: got %h want 0", d); end
        rd(16'h0000, d, lat);
        tests++; if (d !== 32'h0000_00A5) begin fails++; $display("FAIL ctrl_bit31_reads0: got %h want 000000a5", d); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [4];
        logic [31:0] e [4];
        logic exp_vld;
        a = '{16'h0000, 16'h0004, 16'h0002, 16'h0040};
        e = '{32'h0, 32'h1, 32'hDEAD_ADD0, 32'hDEAD_ADD0};
        wr(16'h0000, 32'h0);
        wr(16'h0004, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_vld = (i >= 2 && i <= 5);
            tests++; if (rd_dvalid !== exp_vld) begin fails++; $display("FAIL b2b_dvalid[%0d]: got %b want %b", i, rd_dvalid, exp_vld); end
            if (i >= 2 && i <= 5) begin
                tests++; if (rd_data !== e[i-2]) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", i-2, rd_data, e[i-2]); end
            end
            if (i < 4) begin rd_en = 1'b1; wr_rd_addr = a[i]; end
            else rd_en = 1'b0;
        end
        tests++; if (rd_data !== 32'hDEAD_ADD0) begin fails++; $display("FAIL b2b_hold: got %h want deadadd0", rd_data); end
    endtask

    task automatic test_simul_rw();
        int lat;
        @(negedge clk);
        wr_rd_addr = 16'h0004; wr_data = 32'h55; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        lat = 1;
        while (lat < 8 && !rd_dvalid) begin @(negedge clk); lat++; end
        tests++; if (lat !== 2) begin fails++; $display("FAIL simul_latency: got %0d want 2", lat); end
        tests++; if (rd_data !== 32'h1) begin fails++; $display("FAIL simul_old_value: got %h want 1", rd_data); end
        tests++; if (mode_out !== 32'h55) begin fails++; $display("FAIL simul_mode_out: got %h want 55", mode_out); end
    endtask

    task automatic test_reset_mid_read();
        wr(16'h0000, 32'h0000_0033);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 2) begin rd_en = 1'b1; wr_rd_addr = 16'h0004; end
            else rd_en = 1'b0;
            if (i == 2) rst_n = 1'b0;
            if (i == 4) rst_n = 1'b1;
            #1;
            if (i >= 2) begin
                tests++; if (rd_dvalid !== 1'b0) begin fails++; $display("FAIL midreset_dvalid[%0d]: got %b want 0", i, rd_dvalid); end
            end
        end
        tests++; if (ctrl_out !== 32'h0) begin fails++; $display("FAIL midreset_ctrl: got %h want 0", ctrl_out); end
        tests++; if (mode_out !== 32'h1) begin fails++; $display("FAIL midreset_mode: got %h want 1", mode_out); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL midreset_rd_data: got %h want 0", rd_data); end
    endtask

    task automatic test_csr_wr_cnt();
        logic [31:0] d; int lat;
        wr(16'h0000, 32'h8000_0000);
        wr(16'h0040, 32'h1);
        wr(16'h0004, 32'h77);
        wr(16'h0002, 32'h3);
        tests++; if (mode_out !== 32'h77) begin fails++; $display("FAIL unmapped_wr_mode: got %h want 77", mode_out); end
        tests++; if (ctrl_out !== 32'h0) begin fails++; $display("FAIL unmapped_wr_ctrl: got %h want 0", ctrl_out); end
        rd(16'h0018, d, lat);
`ifdef CSR_WR_CNT_EN
        tests++; if (d !== 32'h3) begin fails++; $display("FAIL csr_wr_cnt: got %h want 3", d); end
`else
        tests++; if (d !== 32'hDEAD_ADD0) begin fails++; $display("FAIL csr_wr_cnt_unmapped: got %h want deadadd0", d); end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ctrl_mode();
        test_err();
        test_counters();
        test_back_to_back();
        test_simul_rw();
        test_reset_mid_read();
        test_csr_wr_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
